// File: rtl/io_tx_controller_if.sv
// img_sram_intf: image SRAM port; the master presents row/col and controls, the SRAM returns dout.
interface img_sram_intf;
    logic [7:0] row;
    logic [7:0] col;
    logic [7:0] din;
    logic [7:0] dout;
    logic       sense_en;
    logic       write_en;
    modport mst (output row, col, sense_en, write_en, din, input dout);
    modport slv (input row, col, sense_en, write_en, din, output dout);
endinterface

// File: rtl/io_tx_controller.sv
// io_tx_controller: streams a stored image out of the SRAM in raster order onto a valid/ready byte bus.
// Optional IO_TX_LAST_EN adds dout_last, flagging the final pixel of each frame.
module io_tx_controller #(
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic [7:0] nrows,
    input  logic [7:0] ncols,
    output logic [7:0] dout,
    output logic       dout_valid,
`ifdef IO_TX_LAST_EN
    output logic       dout_last,
`endif
    input  logic       dout_ready,
    output logic       busy,
    img_sram_intf.mst  sram_img
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
`ifdef IO_TX_LAST_EN
    localparam int DW = 9;
`else
    localparam int DW = 8;
`endif

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [7:0]        nrows_q, ncols_q, row_q, col_q, row_d, col_d;
    logic [CW-1:0]     fcnt_q, fcnt_d, infl_q, infl_d;
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [DW-1:0]     mem_q [FIFO_DEPTH];
    logic [RD_LAT-1:0] vld_q;
    logic              busy_q, issue, at_end, push, pop;
    logic [DW-1:0]     wdata, head;
`ifdef IO_TX_LAST_EN
    logic [RD_LAT-1:0] lst_q;
`endif

    assign sram_img.row      = row_q;
    assign sram_img.col      = col_q;
    assign sram_img.sense_en = 1'b1;
    assign sram_img.write_en = 1'b0;
    assign sram_img.din      = 8'd0;
    assign busy              = busy_q;

    always_comb begin
        at_end     = (row_q == nrows_q) && (col_q == ncols_q);
        // credit covers both buffered data and reads still in the SRAM pipeline
        issue      = (state_q == READ) && (({1'b0, fcnt_q} + {1'b0, infl_q}) < (CW + 1)'(FIFO_DEPTH));
        push       = vld_q[RD_LAT-1];
        dout_valid = fcnt_q != '0;
        pop        = dout_valid && dout_ready;
        fcnt_d     = fcnt_q + CW'(push) - CW'(pop);
        infl_d     = infl_q + CW'(issue) - CW'(push);
        head       = mem_q[rptr_q];
        dout       = dout_valid ? head[7:0] : 8'd0;
`ifdef IO_TX_LAST_EN
        dout_last  = dout_valid && head[8];
        wdata      = {lst_q[RD_LAT-1], sram_img.dout};
`else
        wdata      = sram_img.dout;
`endif
        col_d      = (state_q == IDLE) ? 8'd0 : issue ? ((col_q == ncols_q) ? 8'd0 : col_q + 8'd1) : col_q;
        row_d      = (state_q == IDLE) ? 8'd0 : (issue && col_q == ncols_q) ? row_q + 8'd1 : row_q;
        case (state_q)
            IDLE:    state_d = en ? READ : IDLE;
            READ:    state_d = (issue && at_end) ? DRAIN : READ;
            default: state_d = (infl_d == '0 && fcnt_d == '0) ? IDLE : DRAIN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            nrows_q <= '0;
            ncols_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            fcnt_q  <= '0;
            infl_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            vld_q   <= '0;
`ifdef IO_TX_LAST_EN
            lst_q   <= '0;
`endif
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= state_d != IDLE;
            row_q   <= row_d;
            col_q   <= col_d;
            fcnt_q  <= fcnt_d;
            infl_q  <= infl_d;
            vld_q   <= RD_LAT'({vld_q, issue});
`ifdef IO_TX_LAST_EN
            lst_q   <= RD_LAT'({lst_q, issue && at_end});
`endif
            if (state_q == IDLE && en) begin
                nrows_q <= nrows;
                ncols_q <= ncols;
            end
            if (push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop) rptr_q <= rptr_q + AW'(1);
        end
    end
endmodule

// File: tb/tb_io_tx_controller.sv
// tb_io_tx_controller: directed frames against a registered-read SRAM model holding pix = row*16+col.
module tb_io_tx_controller;
    logic       clk = 1'b0, rstn = 1'b0, en = 1'b0, dout_ready = 1'b0;
    logic [7:0] nrows = 8'd0, ncols = 8'd0, dout;
    logic       dout_valid, busy;
`ifdef IO_TX_LAST_EN
    logic       dout_last;
    logic       last_flag;
`endif
    int         total = 0, bad = 0;
    int         xfers, first_v, end_c, errs, max_out;
    logic [15:0] stall_addr;
    logic [7:0]  last_dout;

    img_sram_intf sram ();

    io_tx_controller #(.RD_LAT(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .en(en), .nrows(nrows), .ncols(ncols),
        .dout(dout), .dout_valid(dout_valid),
`ifdef IO_TX_LAST_EN
        .dout_last(dout_last),
`endif
        .dout_ready(dout_ready), .busy(busy), .sram_img(sram)
    );

    always #5 clk = ~clk;
    always_ff @(posedge clk) sram.dout <= 8'(sram.row * 8'd16 + sram.col);

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'((r * 16 + c) & 255);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: ready held high; mode 1: ready 1,0,0,1 repeating. ready is 0 for the first `stall` cycles.
    task automatic run_frame(input int nr, input int nc, input int mode, input int stall,
                             input int budget, input int abort_at);
        int r = 0, cc = 0, issued = 0;
        logic was_stall = 1'b0;
        logic [7:0] held = 8'd0;
        logic [15:0] prev;
        nrows = 8'(nr); ncols = 8'(nc); en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0; nrows = ~8'(nr); ncols = ~8'(nc);
        xfers = 0; first_v = -1; end_c = -1; errs = 0; max_out = 0; stall_addr = 16'hffff;
        prev = {sram.row, sram.col};
        for (int c = 0; c < budget; c++) begin
            if (!busy) begin end_c = c; break; end
            if (abort_at > 0 && xfers == abort_at) break;
            if ({sram.row, sram.col} != prev) issued++;
            prev = {sram.row, sram.col};
            if (issued - xfers > max_out) max_out = issued - xfers;
            if (c == stall - 1) stall_addr = {sram.row, sram.col};
            dout_ready = (c < stall) ? 1'b0 : (mode == 0) ? 1'b1 : (c % 4 == 0 || c % 4 == 3);
            if (was_stall && (!dout_valid || dout !== held)) errs++;
            if (dout_valid && first_v < 0) first_v = c;
            if (dout_valid && dout_ready) begin
                if (dout !== pix(r, cc)) errs++;
`ifdef IO_TX_LAST_EN
                if (dout_last !== (r == nr && cc == nc)) errs++;
                last_flag = dout_last;
`endif
                last_dout = dout;
                xfers++;
                if (cc == nc) begin cc = 0; r++; end else cc++;
            end
            was_stall = dout_valid && !dout_ready;
            held = dout;
            @(posedge clk); #1;
        end
        dout_ready = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_addr", {sram.row, sram.col}, 0);
        chk("sram_static", {sram.sense_en, sram.write_en, sram.din}, 10'h200);
        @(posedge clk); #1; rstn = 1'b1;
        @(posedge clk); #1;

        run_frame(1, 2, 0, 0, 100, 0);
        chk("a_xfers", xfers, 6);
        chk("a_first_valid", first_v, 2);
        chk("a_busy_end", end_c, 8);
        chk("a_errs", errs, 0);

        run_frame(0, 0, 0, 0, 100, 0);
        chk("one_xfers", xfers, 1);
        chk("one_errs", errs, 0);
        chk("one_busy_end", end_c, 3);
`ifdef IO_TX_LAST_EN
        chk("one_last", last_flag, 1);
`endif

        run_frame(3, 3, 1, 0, 300, 0);
        chk("tog_xfers", xfers, 16);
        chk("tog_errs", errs, 0);
        chk("tog_outstanding_ok", max_out <= 4, 1);

        run_frame(1, 7, 0, 50, 300, 0);
        chk("stall_xfers", xfers, 16);
        chk("stall_errs", errs, 0);
        chk("stall_addr", stall_addr, 16'h0004);
        chk("stall_outstanding", max_out, 4);

        run_frame(255, 255, 0, 0, 70000, 0);
        chk("big_xfers", xfers, 65536);
        chk("big_first_valid", first_v, 2);
        chk("big_busy_end", end_c, 65538);
        chk("big_errs", errs, 0);
        chk("big_last_pix", last_dout, 8'hef);

        run_frame(3, 3, 0, 0, 200, 5);
        chk("abort_xfers", xfers, 5);
        rstn = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", dout_valid, 0);
        chk("abort_dout", dout, 0);
        chk("abort_addr", {sram.row, sram.col}, 0);
        @(posedge clk); #1; rstn = 1'b1;
        @(posedge clk); #1;
        run_frame(3, 3, 0, 0, 200, 0);
        chk("restart_xfers", xfers, 16);
        chk("restart_first_valid", first_v, 2);
        chk("restart_errs", errs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
